hysteresis_tracker: RTL and testbench
=====================================

# hysteresis_tracker

Single-pass causal hysteresis edge tracker placed directly downstream of the edge-detection pipeline. Consumes the 2-bit per-pixel threshold class stream (`out_pix`, qualified by `ready`) and promotes weak pixels to edges when an already-resolved neighbour is an edge. Emits a 1-bit binary edge map with line and frame markers. Keeps a one-line buffer of resolved edge bits and raster row/column counters.

## Interface
- `WIDTH`, default 320: image width in pixels, ≥ 2.
- `HEIGHT`, default 240: image height in lines, ≥ 2.
- `CNT_W`, default 17: width of the edge counter; must satisfy 2^CNT_W > WIDTH*HEIGHT.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  pixel qualifier; driven by the upstream `ready`.
- `in_sof`  in  1  start of frame; sampled only when `in_valid`=1.
- `in_class`  in  2  class: 00 none, 01 weak, 10 strong, 11 treated as strong.
- `out_valid`  out  1  output pixel qualifier.
- `out_edge`  out  1  resolved edge bit.
- `out_sol`  out  1  first pixel of a line (x=0).
- `out_eof`  out  1  last pixel of a frame (x=WIDTH-1, y=HEIGHT-1).
- `edge_count`  out  CNT_W  edge pixels in the last completed frame (see Configuration).

## Operation
- Counters: `col` runs 0..WIDTH-1 and `row` runs 0..HEIGHT-1. Both advance only on `in_valid`.
- `col` wraps to 0 at WIDTH-1 and `row` increments. At (WIDTH-1, HEIGHT-1) both wrap to 0.
- An accepted pixel with `in_sof`=1 is forced to position (0,0), whatever the counter values. Counters then continue from (1,0).
- Decision for pixel (x,y):
  - edge = strong OR (weak AND (L OR UL OR U OR UR)).
  - L = resolved bit at (x-1,y).
  - UL, U, UR = resolved bits at (x-1,y-1), (x,y-1), (x+1,y-1).
- Masking:
  - y=0: UL, U and UR are forced to 0.
  - x=0: L and UL are forced to 0.
  - x=WIDTH-1: UR is forced to 0.
  - Line-buffer contents are never consulted for row 0. Stale data after reset or an sof resync therefore has no effect.
- Line buffer: WIDTH×1 bit. The resolved bit of (x,y) overwrites entry x in the same cycle as the output.
  - UL and U must come from registered copies of the previous row, not from the overwritten entries.
  - Only UR (entry x+1) is read directly from the buffer.
- There is no backpressure. Every accepted pixel produces exactly one output.
- Idle cycles (`in_valid`=0) hold all counters and buffer contents unchanged.

## Timing
- Latency is 1 cycle. A pixel accepted at edge N appears on `out_valid`/`out_edge`/`out_sol`/`out_eof` after edge N.
- All outputs are registered. When `in_valid`=0 the next cycle has `out_valid`=0, and `out_edge`/`out_sol`/`out_eof` are 0.
- Full throughput: one pixel per clock, sustained indefinitely.
- Reset values: `out_valid`=0, `out_edge`=0, `out_sol`=0, `out_eof`=0, `edge_count`=0, `col`=0, `row`=0, running counter=0.
- Reset mid-frame: the next accepted pixel is treated as (0,0) with row-0 masking. Any in-flight output is dropped.
- `rst` has priority over `in_valid`. A pixel presented during reset is discarded.
- `in_sof` on a pixel already at (0,0) has no additional effect.

## Configuration
- `HYST_EDGE_COUNT_EN` defined:
  - A running CNT_W counter increments for each output with `out_edge`=1.
  - On the cycle `out_eof`=1, `edge_count` loads the final total including that pixel, and the running counter restarts at 0.
  - The running counter also restarts when a pixel is forced to (0,0) by `in_sof`.
- Not defined: the counters are not built and `edge_count` is tied to 0.

## Test plan
All scenarios use WIDTH=4, HEIGHT=3 and continuous `in_valid`.
- Reset: `rst`=1 for 2 cycles → all outputs 0. First pixel strong → one cycle later `out_valid`=1, `out_edge`=1, `out_sol`=1.
- Row 0 = {strong, weak, weak, none}, rows 1–2 all none → edges 1,1,1,0 (left-chain promotion), then 0s. With `HYST_EDGE_COUNT_EN`, `edge_count`=3 after `out_eof`.
- Row 0 = {none, none, none, strong}, row 1 = {none, none, weak, none} → (2,1)=1 via UR. Same test with row 0 strong at x=0 and row 1 weak at x=3 → (3,1)=0; mask checks, no wrap-around.
- All 12 pixels weak → all `out_edge`=0, `out_eof` pulses exactly on pixel 12, `edge_count`=0.
- Mid-frame `in_sof`: after 6 pixels, assert `in_sof` with a weak pixel → treated as (0,0), `out_sol`=1, `out_edge`=0 (row 0 masked). The next `out_eof` comes 11 pixels later.
- Gaps: toggle `in_valid` 1/0 for one frame → outputs match the continuous-stream results pixel for pixel, with `out_valid`=0 on the gap cycles.

Source files
------------

// File: rtl/hysteresis_tracker.sv
// Causal hysteresis tracker: promotes weak pixels next to resolved edges; optional HYST_EDGE_COUNT_EN adds per-frame edge count.
// Latency: 1 cycle, all outputs registered, one pixel per clock sustained.
// Backpressure: none; every accepted pixel yields exactly one output, idle cycles hold state.
module hysteresis_tracker #(
   parameter int WIDTH  = 320,
   parameter int HEIGHT = 240,
   parameter int CNT_W  = 17
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic             in_sof,
   input  logic [1:0]       in_class,
   output logic             out_valid,
   output logic             out_edge,
   output logic             out_sol,
   output logic             out_eof,
   output logic [CNT_W-1:0] edge_count
);
   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam int RW = (HEIGHT > 2) ? $clog2(HEIGHT) : 1;
   localparam logic [CW-1:0] LAST_COL = CW'(WIDTH - 1);
   localparam logic [RW-1:0] LAST_ROW = RW'(HEIGHT - 1);

   logic [CW-1:0]    col, eff_col, ur_idx;
   logic [RW-1:0]    row, eff_row;
   logic [WIDTH-1:0] line_buf;
   logic             l_reg, u_reg, ul_reg;
   logic             first_row, first_col, last_col, is_eof;
   logic             n_l, n_ul, n_u, n_ur, ur_raw, edge_bit;

   always_comb begin
      eff_col   = in_sof ? '0 : col;
      eff_row   = in_sof ? '0 : row;
      first_col = (eff_col == '0);
      first_row = (eff_row == '0);
      last_col  = (eff_col == LAST_COL);
      is_eof    = last_col && (eff_row == LAST_ROW);
      // At the last column this prefetches entry 0, which becomes U for the next row's x=0
      ur_idx    = last_col ? '0 : eff_col + 1'b1;
      ur_raw    = line_buf[ur_idx];
      n_l       = first_col ? 1'b0 : l_reg;
      n_ul      = (first_col || first_row) ? 1'b0 : ul_reg;
      n_u       = first_row ? 1'b0 : u_reg;
      n_ur      = (first_row || last_col) ? 1'b0 : ur_raw;
      edge_bit  = in_class[1] | (in_class[0] & (n_l | n_ul | n_u | n_ur));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         col       <= '0;
         row       <= '0;
         l_reg     <= 1'b0;
         u_reg     <= 1'b0;
         ul_reg    <= 1'b0;
         out_valid <= 1'b0;
         out_edge  <= 1'b0;
         out_sol   <= 1'b0;
         out_eof   <= 1'b0;
      end else begin
         out_valid <= in_valid;
         out_edge  <= in_valid & edge_bit;
         out_sol   <= in_valid & first_col;
         out_eof   <= in_valid & is_eof;
         if (in_valid) begin
            l_reg  <= edge_bit;
            u_reg  <= ur_raw;
            ul_reg <= u_reg;
            if (last_col) begin
               col <= '0;
               row <= (eff_row == LAST_ROW) ? '0 : eff_row + 1'b1;
            end else begin
               col <= eff_col + 1'b1;
               row <= eff_row;
            end
         end
      end
   end

   // Buffer contents need no reset: row 0 never reads them
   always_ff @(posedge clk) begin
      if (!rst && in_valid)
         line_buf[eff_col] <= edge_bit;
   end

`ifdef HYST_EDGE_COUNT_EN
   logic [CNT_W-1:0] run_cnt, run_base, run_next;

   always_comb begin
      run_base = in_sof ? '0 : run_cnt;
      run_next = run_base + {{(CNT_W-1){1'b0}}, edge_bit};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         run_cnt    <= '0;
         edge_count <= '0;
      end else if (in_valid) begin
         if (is_eof) begin
            edge_count <= run_next;
            run_cnt    <= '0;
         end else begin
            run_cnt    <= run_next;
         end
      end
   end
`else
   assign edge_count = '0;
`endif
endmodule

// File: tb/tb_hysteresis_tracker.sv
// Scoreboard bench for hysteresis_tracker at 4x3: stimulus pushes expected outputs, a monitor pops and compares.
module tb_hysteresis_tracker;
   localparam int W  = 4;
   localparam int H  = 3;
   localparam int CN = 17;
   localparam logic [1:0] N = 2'd0, WK = 2'd1, S = 2'd2;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          in_valid = 1'b0;
   logic          in_sof = 1'b0;
   logic [1:0]    in_class = 2'd0;
   logic          out_valid, out_edge, out_sol, out_eof;
   logic [CN-1:0] edge_count;

   int checks = 0;
   int errors = 0;
   bit mon_en = 1'b0;

   typedef struct {
      logic e_edge;
      logic e_sol;
      logic e_eof;
      int   e_ec;
   } exp_t;
   exp_t exp_q[$];

   always #5 clk = ~clk;

   hysteresis_tracker #(.WIDTH(W), .HEIGHT(H), .CNT_W(CN)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof), .in_class(in_class),
      .out_valid(out_valid), .out_edge(out_edge), .out_sol(out_sol), .out_eof(out_eof),
      .edge_count(edge_count)
   );

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
      end
   endtask

   function automatic int ec_exp(input int v);
`ifdef HYST_EDGE_COUNT_EN
      return v;
`else
      return 0 * v;
`endif
   endfunction

   always @(negedge clk) begin
      exp_t e;
      if (mon_en) begin
         if (out_valid) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_out_valid", 1, 0);
            end else begin
               e = exp_q.pop_front();
               chk("out_edge", int'(out_edge), int'(e.e_edge));
               chk("out_sol", int'(out_sol), int'(e.e_sol));
               chk("out_eof", int'(out_eof), int'(e.e_eof));
               if (e.e_eof) chk("edge_count", int'(edge_count), ec_exp(e.e_ec));
            end
         end else begin
            chk("idle_outputs_zero", int'({out_edge, out_sol, out_eof}), 0);
         end
      end
   end

   task automatic pix(input logic sof, input logic [1:0] cls, input logic e,
                      input logic s, input logic f, input int ec);
      exp_t x;
      @(posedge clk); #1;
      in_valid = 1'b1; in_sof = sof; in_class = cls;
      x.e_edge = e; x.e_sol = s; x.e_eof = f; x.e_ec = ec;
      exp_q.push_back(x);
   endtask

   task automatic idle();
      @(posedge clk); #1;
      in_valid = 1'b0; in_sof = 1'b0; in_class = 2'd0;
   endtask

   task automatic frame(input logic [1:0] cls [12], input logic ed [12], input int ec,
                        input bit sof0, input bit gaps);
      for (int i = 0; i < W * H; i++) begin
         pix(sof0 && (i == 0), cls[i], ed[i], (i % W) == 0, i == W * H - 1, ec);
         if (gaps) idle();
      end
   endtask

   task automatic do_reset(input int n);
      @(posedge clk); #1;
      rst = 1'b1; in_valid = 1'b1; in_sof = 1'b0; in_class = S;
      repeat (n) @(posedge clk);
      #1;
      rst = 1'b0; in_valid = 1'b0; in_class = N;
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_out_edge", int'(out_edge), 0);
      chk("rst_out_sol", int'(out_sol), 0);
      chk("rst_out_eof", int'(out_eof), 0);
      chk("rst_edge_count", int'(edge_count), 0);
      rst = 1'b0;
      mon_en = 1'b1;

      // left-chain promotion in row 0
      frame('{S,WK,WK,N, N,N,N,N, N,N,N,N}, '{1,1,1,0, 0,0,0,0, 0,0,0,0}, 3, 1'b1, 1'b0);
      // UR promotion, UL promotion at last column; sof at (0,0) is a no-op
      frame('{N,N,N,S, N,N,WK,N, N,N,N,WK}, '{0,0,0,1, 0,0,1,0, 0,0,0,1}, 3, 1'b1, 1'b0);
      // all weak, stale buffer must not leak into row 0
      frame('{WK,WK,WK,WK, WK,WK,WK,WK, WK,WK,WK,WK}, '{0,0,0,0, 0,0,0,0, 0,0,0,0}, 0, 1'b0, 1'b0);
      // UR masked at last column (entry 0 holds a 1)
      frame('{S,N,N,N, S,N,N,WK, N,N,N,N}, '{1,0,0,0, 1,0,0,0, 0,0,0,0}, 2, 1'b0, 1'b0);
      // L masked at first column (previous pixel is an edge)
      frame('{N,N,N,S, WK,N,N,N, N,N,N,N}, '{0,0,0,1, 0,0,0,0, 0,0,0,0}, 1, 1'b0, 1'b0);
      // U promotion
      frame('{N,S,N,N, N,WK,N,N, N,N,N,N}, '{0,1,0,0, 0,1,0,0, 0,0,0,0}, 2, 1'b0, 1'b0);

      // mid-frame sof resync
      for (int i = 0; i < 6; i++) pix(1'b0, S, 1'b1, (i % W) == 0, 1'b0, 0);
      pix(1'b1, WK, 1'b0, 1'b1, 1'b0, 0);
      for (int j = 1; j < W * H; j++) pix(1'b0, N, 1'b0, (j % W) == 0, j == W * H - 1, 0);

      // gapped stream must match the continuous result
      frame('{N,N,N,S, N,N,WK,N, N,N,N,WK}, '{0,0,0,1, 0,0,1,0, 0,0,0,1}, 3, 1'b0, 1'b1);

      // reset mid-frame; pixels presented during reset are dropped
      for (int i = 0; i < 5; i++) pix(1'b0, S, 1'b1, (i % W) == 0, 1'b0, 0);
      do_reset(2);
      frame('{WK,WK,N,N, N,N,N,N, N,N,N,N}, '{0,0,0,0, 0,0,0,0, 0,0,0,0}, 0, 1'b0, 1'b0);

      idle();
      for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(posedge clk);
      repeat (2) @(posedge clk);
      chk("scoreboard_drained", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
